uart_tx_prog: RTL and testbench



---
 rtl/uart_tx_prog.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_prog.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_prog.sv
// uart_tx_prog: 8N1 UART transmitter with a run-time programmable bit period.
//
// Each request is serialized as start bit, DATA_BITS data bits LSB first and a
// stop bit. CLKS_PER_BIT (clk_i frequency / baud rate) is sampled when a frame
// starts, so changing it mid-frame only affects the next frame. Values 0 and 1
// are clamped to 2. A one-deep holding register lets the front-end stage the
// next byte while the current one shifts out; a staged byte starts directly
// from the CLEANUP cycle, giving back-to-back frames.
//
// Optional feature (macro UART_TX_PARITY_EN): adds i_Parity_En / i_Parity_Odd,
// both sampled at frame start. With i_Parity_En=1 a parity bit (even, or odd
// when i_Parity_Odd=1) is inserted between the data bits and the stop bit.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   i_Tx_DV       transmit request, i_Tx_Byte valid this cycle
//   i_Tx_Byte     byte to transmit
//   CLKS_PER_BIT  clocks per bit, sampled at frame start
//   i_Parity_En   (UART_TX_PARITY_EN only) insert a parity bit
//   i_Parity_Odd  (UART_TX_PARITY_EN only) odd instead of even parity
//   o_Tx_Serial   serial line, idles high
//   o_Tx_Active   high while a frame is in progress
//   o_Tx_Done     one-cycle pulse in the cycle after the stop bit
//   o_Tx_Ready    high when a new request will be accepted

module uart_tx_prog #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    input  logic [15:0]          CLKS_PER_BIT,
`ifdef UART_TX_PARITY_EN
    input  logic                 i_Parity_En,
    input  logic                 i_Parity_Odd,
`endif
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done,
    output logic                 o_Tx_Ready
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        CLEANUP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_full;
    logic [15:0]          bit_period;
    logic [15:0]          clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
`ifdef UART_TX_PARITY_EN
    logic                 parity_en;
    logic                 parity_bit;
`endif

    logic [15:0]          cpb_eff;
    logic [DATA_BITS-1:0] frame_byte;
    logic                 bit_last;
    logic                 start_from_hold;
    logic                 start_from_dv;
    logic                 load_frame;
    logic                 hold_load;

    // Illegal periods 0 and 1 are clamped so the counter compare never underflows.
    assign cpb_eff  = (CLKS_PER_BIT < 16'd2) ? 16'd2 : CLKS_PER_BIT;
    assign bit_last = (clk_cnt == bit_period - 16'd1);

    // A staged byte always takes priority over a fresh request when a frame starts.
    assign start_from_hold = hold_full && ((state == IDLE) || (state == CLEANUP));
    assign start_from_dv   = (state == IDLE) && !hold_full && i_Tx_DV;
    assign load_frame      = start_from_hold || start_from_dv;
    assign frame_byte      = hold_full ? hold_reg : i_Tx_Byte;

    // Requests arriving while a frame is in flight go to the holding register;
    // requests while it is full are silently dropped.
    assign hold_load  = i_Tx_DV && !hold_full && (state != IDLE);
    assign o_Tx_Ready = ~hold_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            shift_reg   <= '0;
            hold_reg    <= '0;
            hold_full   <= 1'b0;
            bit_period  <= 16'd2;
            clk_cnt     <= 16'd0;
            bit_idx     <= '0;
`ifdef UART_TX_PARITY_EN
            parity_en   <= 1'b0;
            parity_bit  <= 1'b0;
`endif
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;

            if (hold_load) begin
                hold_reg  <= i_Tx_Byte;
                hold_full <= 1'b1;
            end else if (start_from_hold) begin
                hold_full <= 1'b0;
            end

            case (state)
                IDLE, CLEANUP: begin
                    o_Tx_Serial <= 1'b1;
                    if (load_frame) begin
                        shift_reg   <= frame_byte;
                        bit_period  <= cpb_eff;
                        clk_cnt     <= 16'd0;
                        bit_idx     <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_en   <= i_Parity_En;
                        parity_bit  <= (^frame_byte) ^ i_Parity_Odd;
`endif
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        state       <= START;
                    end else begin
                        state <= IDLE;
                    end
                end

                START: begin
                    if (bit_last) begin
                        clk_cnt     <= 16'd0;
                        bit_idx     <= '0;
                        o_Tx_Serial <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        state       <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end

                // The shift register is consumed LSB first; bit_idx only counts bits.
                DATA: begin
                    if (bit_last) begin
                        clk_cnt <= 16'd0;
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            if (parity_en) begin
                                o_Tx_Serial <= parity_bit;
                                state       <= PARITY;
                            end else begin
                                o_Tx_Serial <= 1'b1;
                                state       <= STOP;
                            end
`else
                            o_Tx_Serial <= 1'b1;
                            state       <= STOP;
`endif
                        end else begin
                            bit_idx     <= bit_idx + 1'b1;
                            o_Tx_Serial <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_last) begin
                        clk_cnt     <= 16'd0;
                        o_Tx_Serial <= 1'b1;
                        state       <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`endif

                // Done and the drop of Active are registered here so they appear
                // together during the single CLEANUP cycle.
                STOP: begin
                    if (bit_last) begin
                        clk_cnt     <= 16'd0;
                        o_Tx_Done   <= 1'b1;
                        o_Tx_Active <= 1'b0;
                        state       <= CLEANUP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end

                default: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_prog.sv
// tb_uart_tx_prog: self-checking bench for uart_tx_prog.
//
// A table of {byte, CLKS_PER_BIT, mid-frame CLKS_PER_BIT, effective period}
// records drives single frames whose line waveform is compared bit by bit
// against a frame built from the byte. Hand-written sequences cover reset
// state, reset mid-frame, back-to-back frames with a dropped request, a very
// long bit period and (with UART_TX_PARITY_EN) the parity bit.

module tb_uart_tx_prog;

    logic        clk_i;
    logic        rst_ni;
    logic        i_Tx_DV;
    logic [7:0]  i_Tx_Byte;
    logic [15:0] CLKS_PER_BIT;
`ifdef UART_TX_PARITY_EN
    logic        i_Parity_En;
    logic        i_Parity_Odd;
`endif
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;
    logic        o_Tx_Ready;

    int testsRun = 0;
    int testsFailed = 0;

    uart_tx_prog #(.DATA_BITS(8)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_Tx_DV      (i_Tx_DV),
        .i_Tx_Byte    (i_Tx_Byte),
        .CLKS_PER_BIT (CLKS_PER_BIT),
`ifdef UART_TX_PARITY_EN
        .i_Parity_En  (i_Parity_En),
        .i_Parity_Odd (i_Parity_Odd),
`endif
        .o_Tx_Serial  (o_Tx_Serial),
        .o_Tx_Active  (o_Tx_Active),
        .o_Tx_Done    (o_Tx_Done),
        .o_Tx_Ready   (o_Tx_Ready)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] cpb;
        logic [15:0] midCpb;
        int          period;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Checks the idle line, then presents one request for exactly one clock.
    // Returns at the falling edge after the accepting rising edge.
    task automatic applyStimulus(input logic [7:0] data, input logic [15:0] cpb,
                                 input string tag);
        @(negedge clk_i);
        checkOutput({tag, " idle serial"}, 32'(o_Tx_Serial), 32'd1);
        checkOutput({tag, " idle ready"}, 32'(o_Tx_Ready), 32'd1);
        checkOutput({tag, " idle active"}, 32'(o_Tx_Active), 32'd0);
        i_Tx_DV      = 1'b1;
        i_Tx_Byte    = data;
        CLKS_PER_BIT = cpb;
        @(negedge clk_i);
        i_Tx_DV      = 1'b0;
    endtask

    // Follows one frame from the first start-bit cycle through the done pulse.
    // CLKS_PER_BIT is switched to midCpb at data bit 3 to show it is ignored.
    task automatic checkFrame(input logic [7:0] data, input int period,
                              input logic [15:0] midCpb, input bit parEn,
                              input bit parBit, input string tag);
        logic frame[11];
        int   nBits;
        int   errs;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[i+1] = data[i];
        if (parEn) begin
            frame[9]  = parBit;
            frame[10] = 1'b1;
            nBits     = 11;
        end else begin
            frame[9]  = 1'b1;
            frame[10] = 1'b1;
            nBits     = 10;
        end
        for (int b = 0; b < nBits; b++) begin
            if (b == 4) CLKS_PER_BIT = midCpb;
            errs = 0;
            for (int c = 0; c < period; c++) begin
                if (o_Tx_Serial !== frame[b] || o_Tx_Active !== 1'b1 || o_Tx_Done !== 1'b0)
                    errs++;
                @(negedge clk_i);
            end
            checkOutput($sformatf("%s bit%0d bad cycles", tag, b), 32'(errs), 32'd0);
        end
        checkOutput({tag, " done pulse"}, 32'(o_Tx_Done), 32'd1);
        checkOutput({tag, " active after stop"}, 32'(o_Tx_Active), 32'd0);
        checkOutput({tag, " serial after stop"}, 32'(o_Tx_Serial), 32'd1);
    endtask

    initial begin
        int errs;

        vecs[0] = '{8'hA5, 16'd4,  16'd9,  4};
        vecs[1] = '{8'h3C, 16'd0,  16'd5,  2};
        vecs[2] = '{8'hC3, 16'd1,  16'd3,  2};
        vecs[3] = '{8'h00, 16'd2,  16'd1,  2};
        vecs[4] = '{8'hFF, 16'd87, 16'd10, 87};
        vecs[5] = '{8'h00, 16'd10, 16'd87, 10};
        vecs[6] = '{8'h5A, 16'd3,  16'd0,  3};
        vecs[7] = '{8'h81, 16'd7,  16'd2,  7};

        rst_ni       = 1'b0;
        i_Tx_DV      = 1'b0;
        i_Tx_Byte    = 8'h00;
        CLKS_PER_BIT = 16'd4;
`ifdef UART_TX_PARITY_EN
        i_Parity_En  = 1'b0;
        i_Parity_Odd = 1'b0;
`endif

        // Reset state
        @(negedge clk_i);
        checkOutput("reset serial", 32'(o_Tx_Serial), 32'd1);
        checkOutput("reset active", 32'(o_Tx_Active), 32'd0);
        checkOutput("reset done", 32'(o_Tx_Done), 32'd0);
        checkOutput("reset ready", 32'(o_Tx_Ready), 32'd1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Table of single frames
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].data, vecs[v].cpb, $sformatf("vec%0d", v));
            checkFrame(vecs[v].data, vecs[v].period, vecs[v].midCpb, 1'b0, 1'b0,
                       $sformatf("vec%0d", v));
            @(negedge clk_i);
            checkOutput($sformatf("vec%0d done cleared", v), 32'(o_Tx_Done), 32'd0);
        end

        // Reset during data bit 3 of 0xA5 (that bit is 0)
        applyStimulus(8'hA5, 16'd4, "rstmid");
        repeat (17) @(negedge clk_i);
        checkOutput("rstmid serial before", 32'(o_Tx_Serial), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rstmid serial async", 32'(o_Tx_Serial), 32'd1);
        checkOutput("rstmid active async", 32'(o_Tx_Active), 32'd0);
        checkOutput("rstmid done async", 32'(o_Tx_Done), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        errs = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (o_Tx_Done !== 1'b0 || o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) errs++;
        end
        checkOutput("rstmid quiet after reset", 32'(errs), 32'd0);
        applyStimulus(8'h3C, 16'd3, "rstmid next");
        checkFrame(8'h3C, 3, 16'd3, 1'b0, 1'b0, "rstmid next");

        // Back-to-back: 0x0F staged mid-frame, 0xEE dropped while full
        applyStimulus(8'h55, 16'd4, "b2b");
        repeat (8) @(negedge clk_i);
        checkOutput("b2b ready before stage", 32'(o_Tx_Ready), 32'd1);
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = 8'h0F;
        @(negedge clk_i);
        i_Tx_DV   = 1'b0;
        checkOutput("b2b ready after stage", 32'(o_Tx_Ready), 32'd0);
        repeat (8) @(negedge clk_i);
        i_Tx_DV   = 1'b1;
        i_Tx_Byte = 8'hEE;
        @(negedge clk_i);
        i_Tx_DV   = 1'b0;
        checkOutput("b2b ready after drop", 32'(o_Tx_Ready), 32'd0);
        repeat (22) @(negedge clk_i);
        checkOutput("b2b first done", 32'(o_Tx_Done), 32'd1);
        checkOutput("b2b cleanup serial", 32'(o_Tx_Serial), 32'd1);
        checkOutput("b2b ready in cleanup", 32'(o_Tx_Ready), 32'd0);
        @(negedge clk_i);
        checkOutput("b2b ready after reload", 32'(o_Tx_Ready), 32'd1);
        checkFrame(8'h0F, 4, 16'd4, 1'b0, 1'b0, "b2b second");
        errs = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) errs++;
        end
        checkOutput("b2b dropped request idle", 32'(errs), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Odd parity of 0x07 (three ones) is 0; even parity of 0x01 is 1
        i_Parity_En  = 1'b1;
        i_Parity_Odd = 1'b1;
        applyStimulus(8'h07, 16'd2, "par odd");
        checkFrame(8'h07, 2, 16'd2, 1'b1, 1'b0, "par odd");
        i_Parity_Odd = 1'b0;
        applyStimulus(8'h01, 16'd3, "par even");
        checkFrame(8'h01, 3, 16'd3, 1'b1, 1'b1, "par even");
        i_Parity_En  = 1'b0;
`endif

        // Maximum period: the start bit must still be low thousands of clocks in
        applyStimulus(8'h80, 16'hFFFF, "maxcpb");
        errs = 0;
        repeat (3000) begin
            if (o_Tx_Serial !== 1'b0 || o_Tx_Active !== 1'b1) errs++;
            @(negedge clk_i);
        end
        checkOutput("maxcpb long start bit", 32'(errs), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("maxcpb abort serial", 32'(o_Tx_Serial), 32'd1);
        checkOutput("maxcpb abort ready", 32'(o_Tx_Ready), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
